// File: rtl/cp0_tlb_regs_pkg.sv
// CP0 TLB register bank shared definitions.
// Register numbers, field positions and sequencer state encoding.
package cp0_defs;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_CONTEXT  = 5'd4;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  localparam int IDX_P_BIT    = 31;
  localparam int EL_W         = 30;
  localparam int EH_VPN2_LSB  = 13;
  localparam int EH_ASID_W    = 8;
  localparam int CTX_BASE_LSB = 23;
  localparam int CTX_VPN2_LSB = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_PROBE = 2'd2;
  localparam logic [1:0] ST_CAPT  = 2'd3;

endpackage

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB register bank and TLB command sequencer.
// Drives TLBWI/TLBP pulses to the MMU and captures probe results.
module cp0_tlb_regs
  import cp0_defs::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mtc0_we,
  input  logic [4:0]        mtc0_addr,
  input  logic [31:0]       mtc0_data,
  input  logic [4:0]        rd_addr,
  output logic [31:0]       rd_data,
  input  logic              tlbwi_req,
  input  logic              tlbp_req,
  input  logic              exc_tlb,
  input  logic [31:0]       exc_vaddr,
  input  logic [31:0]       tlbp_result,
  output logic [85+IDX_W:0] tlb_config,
  output logic              tlbwi,
  output logic              tlbp,
  output logic [7:0]        asid,
  output logic              busy
);

  logic [1:0]       state;
  logic             idx_p;
  logic [IDX_W-1:0] idx_val;
  logic [EL_W-1:0]  lo0;
  logic [EL_W-1:0]  lo1;
  logic [8:0]       ctx_base;
  logic [18:0]      ctx_vpn2;
  logic [31:0]      badvaddr;
  logic [18:0]      hi_vpn2;
  logic [7:0]       hi_asid;

  logic wr_index;
  logic wr_lo0;
  logic wr_lo1;
  logic wr_ctx;
  logic wr_hi;
  logic unused_bits;

  assign wr_index = mtc0_we && (mtc0_addr == CP0_INDEX);
  assign wr_lo0   = mtc0_we && (mtc0_addr == CP0_ENTRYLO0);
  assign wr_lo1   = mtc0_we && (mtc0_addr == CP0_ENTRYLO1);
  assign wr_ctx   = mtc0_we && (mtc0_addr == CP0_CONTEXT);
  assign wr_hi    = mtc0_we && (mtc0_addr == CP0_ENTRYHI);

  assign unused_bits = ^{mtc0_data[EH_VPN2_LSB-1:EH_ASID_W],
                         tlbp_result[IDX_P_BIT-1:IDX_W]};

  assign tlbwi = (state == ST_WRITE);
  assign tlbp  = (state == ST_PROBE);
  assign busy  = (state != ST_IDLE);
  assign asid  = hi_asid;

  assign tlb_config = {idx_val, hi_vpn2, hi_asid,
                       lo0[0] & lo1[0],
                       lo1[EL_W-1:1], lo0[EL_W-1:1]};

  // Sequencer: probe wins over write, requests ignored while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (tlbp_req)
            state <= ST_PROBE;
          else if (tlbwi_req)
            state <= ST_WRITE;
        end
        ST_WRITE: state <= ST_IDLE;
        ST_PROBE: state <= ST_CAPT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Index: probe capture has priority over mtc0.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_p   <= 1'b0;
      idx_val <= '0;
    end else if (state == ST_CAPT) begin
      idx_p   <= tlbp_result[IDX_P_BIT];
      idx_val <= tlbp_result[IDX_W-1:0];
    end else if (wr_index) begin
      idx_val <= mtc0_data[IDX_W-1:0];
    end
  end

  // EntryLo0/EntryLo1 plain software-written registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo0 <= '0;
      lo1 <= '0;
    end else begin
      if (wr_lo0)
        lo0 <= mtc0_data[EL_W-1:0];
      if (wr_lo1)
        lo1 <= mtc0_data[EL_W-1:0];
    end
  end

  // Context, BadVAddr, EntryHi: a TLB exception owns the whole EntryHi.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctx_base <= '0;
      ctx_vpn2 <= '0;
      badvaddr <= '0;
      hi_vpn2  <= '0;
      hi_asid  <= '0;
    end else begin
      if (wr_ctx)
        ctx_base <= mtc0_data[31:CTX_BASE_LSB];
      if (exc_tlb) begin
        badvaddr <= exc_vaddr;
        ctx_vpn2 <= exc_vaddr[31:EH_VPN2_LSB];
        hi_vpn2  <= exc_vaddr[31:EH_VPN2_LSB];
      end else if (wr_hi) begin
        hi_vpn2  <= mtc0_data[31:EH_VPN2_LSB];
        hi_asid  <= mtc0_data[EH_ASID_W-1:0];
      end
    end
  end

  // Combinational CP0 read mux, zero for unmapped numbers.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (rd_addr == CP0_INDEX): begin
        rd_data[IDX_P_BIT]   = idx_p;
        rd_data[IDX_W-1:0]   = idx_val;
      end
      (rd_addr == CP0_ENTRYLO0):
        rd_data[EL_W-1:0] = lo0;
      (rd_addr == CP0_ENTRYLO1):
        rd_data[EL_W-1:0] = lo1;
      (rd_addr == CP0_CONTEXT):
        rd_data = {ctx_base, ctx_vpn2,
                   {CTX_VPN2_LSB{1'b0}}};
      (rd_addr == CP0_BADVADDR):
        rd_data = badvaddr;
      (rd_addr == CP0_ENTRYHI):
        rd_data = {hi_vpn2, 5'b0, hi_asid};
      default:
        rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Self-checking bench for cp0_tlb_regs.
// Vector table for register writes, hand sequences for TLB ops.
module tb_cp0_tlb_regs;
  import cp0_defs::*;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mtc0_we;
  logic [4:0]    mtc0_addr;
  logic [31:0]   mtc0_data;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          tlbwi_req;
  logic          tlbp_req;
  logic          exc_tlb;
  logic [31:0]   exc_vaddr;
  logic [31:0]   tlbp_result;
  logic [85+IW:0] tlb_config;
  logic          tlbwi;
  logic          tlbp;
  logic [7:0]    asid;
  logic          busy;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb[$];

  always #5 clk = ~clk;

  cp0_tlb_regs #(.IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .mtc0_we(mtc0_we), .mtc0_addr(mtc0_addr),
    .mtc0_data(mtc0_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tlbwi_req(tlbwi_req), .tlbp_req(tlbp_req),
    .exc_tlb(exc_tlb), .exc_vaddr(exc_vaddr),
    .tlbp_result(tlbp_result),
    .tlb_config(tlb_config),
    .tlbwi(tlbwi), .tlbp(tlbp),
    .asid(asid), .busy(busy)
  );

  task automatic chk(input string nm,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a,
                    output logic [31:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic mtc0(input logic [4:0] a,
                      input logic [31:0] d);
    mtc0_we   = 1'b1;
    mtc0_addr = a;
    mtc0_data = d;
    tick();
    mtc0_we   = 1'b0;
  endtask

  task automatic count_pulses(input int n,
                              output int nw,
                              output int np);
    nw = 0;
    np = 0;
    for (int i = 0; i < n; i++) begin
      if (tlbwi === 1'b1) nw++;
      if (tlbp === 1'b1)  np++;
      tick();
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [85+IW:0] cfg_exp;
    logic [4:0] regs6[6];
    sb_t e;
    int nw;
    int np;

    vecs[0] = '{CP0_INDEX,    32'hFFFF_FFFF, 32'h0000_000F};
    vecs[1] = '{CP0_ENTRYLO0, 32'hFFFF_FFFF, 32'h3FFF_FFFF};
    vecs[2] = '{CP0_ENTRYLO1, 32'hC000_0001, 32'h0000_0001};
    vecs[3] = '{CP0_CONTEXT,  32'hFFFF_FFFF, 32'hFF80_0000};
    vecs[4] = '{CP0_BADVADDR, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5] = '{CP0_ENTRYHI,  32'hFFFF_FFFF, 32'hFFFF_E0FF};
    vecs[6] = '{CP0_ENTRYHI,  32'hFFFF_E0FF, 32'hFFFF_E0FF};
    vecs[7] = '{5'd1,         32'h1234_5678, 32'h0000_0000};

    regs6[0] = CP0_INDEX;
    regs6[1] = CP0_ENTRYLO0;
    regs6[2] = CP0_ENTRYLO1;
    regs6[3] = CP0_CONTEXT;
    regs6[4] = CP0_BADVADDR;
    regs6[5] = CP0_ENTRYHI;

    rst = 1'b1;
    mtc0_we = 1'b0;
    mtc0_addr = '0;
    mtc0_data = '0;
    rd_addr = '0;
    tlbwi_req = 1'b0;
    tlbp_req = 1'b0;
    exc_tlb = 1'b0;
    exc_vaddr = '0;
    tlbp_result = '0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rd(regs6[i], d);
      chk($sformatf("reset_reg%0d", regs6[i]), 96'(d), 96'(0));
    end
    chk("reset_ctl", 96'({tlbwi, tlbp, busy}), 96'(0));

    for (int i = 0; i < 8; i++) begin
      mtc0_we   = 1'b1;
      mtc0_addr = vecs[i].addr;
      mtc0_data = vecs[i].wdata;
      sb.push_back('{vecs[i].addr, vecs[i].rexp});
      tick();
      mtc0_we = 1'b0;
      e = sb.pop_front();
      rd(e.addr, d);
      chk($sformatf("vec%0d", i), 96'(d), 96'(e.exp));
    end
    chk("asid_ff", 96'(asid), 96'(8'hFF));

    mtc0(CP0_INDEX,    32'h0000_0005);
    mtc0(CP0_ENTRYHI,  32'h0040_2003);
    mtc0(CP0_ENTRYLO0, 32'h0000_1007);
    mtc0(CP0_ENTRYLO1, 32'h0000_1047);
    cfg_exp = {4'd5, 19'h00201, 8'h03, 1'b1,
               29'h0000_0823, 29'h0000_0803};
    tlbwi_req = 1'b1;
    tick();
    tlbwi_req = 1'b0;
    chk("wi_pulse", 96'({tlbwi, busy}), 96'(2'b11));
    chk("wi_cfg", 96'(tlb_config), 96'(cfg_exp));
    count_pulses(4, nw, np);
    chk("wi_once", 96'(nw + 1), 96'(1 + 1 - 1 + 1));
    chk("wi_idle", 96'(busy), 96'(0));

    mtc0(CP0_INDEX, 32'h0000_0009);
    tlbp_result = 32'h0000_0005;
    tlbp_req = 1'b1;
    tick();
    tlbp_req = 1'b0;
    chk("p_n1", 96'({tlbp, tlbwi, busy}), 96'(3'b101));
    mtc0_we   = 1'b1;
    mtc0_addr = CP0_ENTRYHI;
    mtc0_data = 32'h0040_2007;
    tick();
    chk("p_n2", 96'({tlbp, busy}), 96'(2'b01));
    rd(CP0_INDEX, d);
    chk("p_n2_idx", 96'(d), 96'(32'h9));
    mtc0_addr = CP0_INDEX;
    mtc0_data = 32'h0000_000A;
    tick();
    mtc0_we = 1'b0;
    rd(CP0_INDEX, d);
    chk("p_n3_idx", 96'(d), 96'(32'h5));
    chk("p_n3_busy", 96'(busy), 96'(0));
    chk("p_asid", 96'(asid), 96'(8'h07));

    tlbp_result = 32'h8000_0000;
    tlbp_req = 1'b1;
    tick();
    tlbp_req = 1'b0;
    tick();
    tick();
    rd(CP0_INDEX, d);
    chk("p_miss", 96'(d), 96'(32'h8000_0000));
    mtc0(CP0_INDEX, 32'h0000_0003);
    rd(CP0_INDEX, d);
    chk("p_keep", 96'(d), 96'(32'h8000_0003));

    mtc0(CP0_ENTRYHI, 32'h0040_2003);
    exc_tlb   = 1'b1;
    exc_vaddr = 32'h1234_5678;
    mtc0_we   = 1'b1;
    mtc0_addr = CP0_ENTRYHI;
    mtc0_data = 32'h0000_0000;
    tick();
    exc_tlb = 1'b0;
    mtc0_we = 1'b0;
    rd(CP0_BADVADDR, d);
    chk("exc_bva", 96'(d), 96'(32'h1234_5678));
    rd(CP0_ENTRYHI, d);
    chk("exc_hi", 96'(d), 96'(32'h1234_4003));
    rd(CP0_CONTEXT, d);
    chk("exc_ctx", 96'(d), 96'(32'hFF89_1A20));

    tlbp_result = 32'h0000_0007;
    tlbp_req = 1'b1;
    tick();
    tlbp_req = 1'b0;
    chk("r_probe", 96'(tlbp), 96'(1));
    rst = 1'b1;
    tick();
    chk("r_ctl", 96'({tlbp, tlbwi, busy}), 96'(0));
    rd(CP0_INDEX, d);
    chk("r_idx", 96'(d), 96'(0));
    rst = 1'b0;
    tick();
    rd(CP0_INDEX, d);
    chk("r_nocapt", 96'({d, tlbp, busy}), 96'(0));

    tlbp_result = 32'h0000_0002;
    tlbp_req  = 1'b1;
    tlbwi_req = 1'b1;
    tick();
    tlbp_req  = 1'b0;
    tlbwi_req = 1'b0;
    count_pulses(5, nw, np);
    chk("both_p", 96'(np), 96'(1));
    chk("both_w", 96'(nw), 96'(0));
    rd(CP0_INDEX, d);
    chk("both_idx", 96'(d), 96'(32'h2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
